// File: rtl/simon_fifo_to_axi_writer.sv
// simon_fifo_to_axi_writer
// AXI4 write-channel master that drains 128-bit Simon result words from a
// ready/valid FIFO and writes them to memory as INCR bursts. Software loads a
// base address and a beat count, then pulses start; busy/done/error report
// progress. One burst is outstanding at a time and AW always precedes W.
// Bursts are cut at MAX_BURST_BEATS and never cross a 4 KB boundary.
//
// Optional build macro: SIMON_AXI_WR_ERR_ABORT_EN
//   defined   -> a non-OKAY bresp ends the job right after that burst
//   undefined -> the error is recorded and the job runs to completion
module simon_fifo_to_axi_writer #(
   parameter int DATA_DATA_WIDTH = 128,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int DATA_LEN_WIDTH  = 8,
   parameter int DATA_STRB_WIDTH = 16,
   parameter int DATA_RESP_WIDTH = 2,
   parameter int MAX_BURST_BEATS = 16,
   parameter int CNT_WIDTH       = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [DATA_ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]       num_beats,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   input  logic [DATA_DATA_WIDTH-1:0] fifo_din,
   input  logic                       fifo_vld,
   output logic                       fifo_rdy,
   output logic [DATA_ADDR_WIDTH-1:0] simon_block_out_awaddr,
   output logic [DATA_LEN_WIDTH-1:0]  simon_block_out_awlen,
   output logic [2:0]                 simon_block_out_awsize,
   output logic [1:0]                 simon_block_out_awburst,
   output logic                       simon_block_out_awvalid,
   input  logic                       simon_block_out_awready,
   output logic [DATA_DATA_WIDTH-1:0] simon_block_out_wdata,
   output logic [DATA_STRB_WIDTH-1:0] simon_block_out_wstrb,
   output logic                       simon_block_out_wlast,
   output logic                       simon_block_out_wvalid,
   input  logic                       simon_block_out_wready,
   input  logic [DATA_RESP_WIDTH-1:0] simon_block_out_bresp,
   input  logic                       simon_block_out_bvalid,
   output logic                       simon_block_out_bready
);

   // burst lengths run 1..256, so they need one bit more than awlen
   localparam int BW = 9;
   localparam logic [BW-1:0] MAX_BEATS = BW'(MAX_BURST_BEATS);
   localparam logic [DATA_ADDR_WIDTH-1:0] BEAT_ALIGN_MASK =
      {{(DATA_ADDR_WIDTH-4){1'b1}}, 4'h0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_AW,
      S_W,
      S_B,
      S_FIN
   } state_t;

   state_t                     state_reg, state_next;
   logic [DATA_ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [CNT_WIDTH-1:0]       remaining_reg, remaining_next;
   logic [BW-1:0]              len_reg, len_next;
   logic [BW-1:0]              beat_reg, beat_next;
   logic [DATA_ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
   logic [DATA_LEN_WIDTH-1:0]  awlen_reg, awlen_next;
   logic                       error_reg, error_next;

   logic [BW-1:0]              bnd_beats;
   logic [BW-1:0]              cap_beats;
   logic [BW-1:0]              len_calc;
   logic                       last_beat;
   logic                       last_burst;

   // length of the next burst: the smallest of what is left, the burst cap
   // and the beats remaining before the next 4 KB page
   always_comb begin
      bnd_beats = 9'h100 - {1'b0, addr_reg[11:4]};
      cap_beats = (bnd_beats < MAX_BEATS) ? bnd_beats : MAX_BEATS;
      len_calc  = (remaining_reg < CNT_WIDTH'(cap_beats)) ? remaining_reg[BW-1:0]
                                                          : cap_beats;
   end

   assign last_beat  = (beat_reg == len_reg - BW'(1));
   assign last_burst = (remaining_reg == CNT_WIDTH'(len_reg));

   // job sequencing: next state and next datapath values
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      remaining_next = remaining_reg;
      len_next       = len_reg;
      beat_next      = beat_reg;
      awaddr_next    = awaddr_reg;
      awlen_next     = awlen_reg;
      error_next     = error_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               addr_next      = base_addr & BEAT_ALIGN_MASK;
               remaining_next = num_beats;
               error_next     = 1'b0;
               state_next     = (num_beats == '0) ? S_FIN : S_CALC;
            end
         end
         S_CALC: begin
            len_next    = len_calc;
            awaddr_next = addr_reg;
            awlen_next  = DATA_LEN_WIDTH'(len_calc - BW'(1));
            beat_next   = '0;
            state_next  = S_AW;
         end
         S_AW: begin
            if (simon_block_out_awready) begin
               state_next = S_W;
            end
         end
         S_W: begin
            if (fifo_vld && simon_block_out_wready) begin
               if (last_beat) begin
                  state_next = S_B;
               end else begin
                  beat_next = beat_reg + BW'(1);
               end
            end
         end
         S_B: begin
            if (simon_block_out_bvalid) begin
               addr_next      = addr_reg + DATA_ADDR_WIDTH'({len_reg, 4'h0});
               remaining_next = remaining_reg - CNT_WIDTH'(len_reg);
               state_next     = last_burst ? S_FIN : S_CALC;
               if (simon_block_out_bresp != '0) begin
                  error_next = 1'b1;
`ifdef SIMON_AXI_WR_ERR_ABORT_EN
                  state_next = S_FIN;
`endif
               end
            end
         end
         S_FIN: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // state and datapath registers; reset abandons any job in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         addr_reg      <= '0;
         remaining_reg <= '0;
         len_reg       <= '0;
         beat_reg      <= '0;
         awaddr_reg    <= '0;
         awlen_reg     <= '0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         remaining_reg <= remaining_next;
         len_reg       <= len_next;
         beat_reg      <= beat_next;
         awaddr_reg    <= awaddr_next;
         awlen_reg     <= awlen_next;
         error_reg     <= error_next;
      end
   end

   // status and handshake outputs decode straight from the state
   assign busy  = (state_reg == S_CALC) || (state_reg == S_AW) ||
                  (state_reg == S_W)    || (state_reg == S_B);
   assign done  = (state_reg == S_FIN);
   assign error = error_reg;

   assign simon_block_out_awaddr  = awaddr_reg;
   assign simon_block_out_awlen   = awlen_reg;
   assign simon_block_out_awsize  = 3'd4;
   assign simon_block_out_awburst = 2'b01;
   assign simon_block_out_awvalid = (state_reg == S_AW);

   // W passes the FIFO through: valid follows the FIFO, the pop follows wready
   assign simon_block_out_wdata  = fifo_din;
   assign simon_block_out_wvalid = (state_reg == S_W) && fifo_vld;
   assign simon_block_out_wlast  = (state_reg == S_W) && last_beat;
   assign fifo_rdy               = (state_reg == S_W) && simon_block_out_wready;

   assign simon_block_out_bready = (state_reg == S_B);

   genvar gi;
   generate
      for (gi = 0; gi < DATA_STRB_WIDTH; gi++) begin : g_strb
         assign simon_block_out_wstrb[gi] = 1'b1;
      end
   endgenerate

endmodule

// File: tb/tb_simon_fifo_to_axi_writer.sv
// Testbench for simon_fifo_to_axi_writer: a random-stimulus environment
// (FIFO, AXI slave) drives the DUT; each job is planned by a reference model
// that pushes the expected AW/W/done events into queues, and an independent
// monitor pops and compares them as the DUT presents them.
module tb_simon_fifo_to_axi_writer;

   localparam int MAXB = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  base_addr;
   logic [19:0]  num_beats;
   logic         busy, done, error;
   logic [127:0] fifo_din;
   logic         fifo_vld;
   logic         fifo_rdy;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast, wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   simon_fifo_to_axi_writer dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .base_addr               (base_addr),
      .num_beats               (num_beats),
      .busy                    (busy),
      .done                    (done),
      .error                   (error),
      .fifo_din                (fifo_din),
      .fifo_vld                (fifo_vld),
      .fifo_rdy                (fifo_rdy),
      .simon_block_out_awaddr  (awaddr),
      .simon_block_out_awlen   (awlen),
      .simon_block_out_awsize  (awsize),
      .simon_block_out_awburst (awburst),
      .simon_block_out_awvalid (awvalid),
      .simon_block_out_awready (awready),
      .simon_block_out_wdata   (wdata),
      .simon_block_out_wstrb   (wstrb),
      .simon_block_out_wlast   (wlast),
      .simon_block_out_wvalid  (wvalid),
      .simon_block_out_wready  (wready),
      .simon_block_out_bresp   (bresp),
      .simon_block_out_bvalid  (bvalid),
      .simon_block_out_bready  (bready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard queues
   logic [31:0]  exp_aw_addr[$];
   logic [7:0]   exp_aw_len[$];
   logic [128:0] exp_w[$];      // {last, data}
   bit           exp_done[$];   // expected error flag at done
   logic [127:0] fifo_q[$];     // FIFO contents as the DUT sees them

   int checks = 0;
   int errors = 0;

   // environment knobs and state
   int pending_b = 0, b_idx = 0, err_burst = -1;
   int aw_delay = 0, aw_low = 0, bp_mode = 0;
   int w_pops = 0, done_cnt = 0;
   int start_cyc = 0, bfire_cyc = 0;
   bit first_aw_wait = 0, zero_job = 0, aw_hold = 0, prev_done = 0, busy_chk = 0;
   logic [31:0] hold_addr;
   logic [7:0]  hold_len;

   function automatic void chk(input bit ok, input string name,
                               input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   // AXI slave and FIFO source: decide handshakes mid-cycle, update after the edge
   initial begin : driver
      bit f_pop, f_aw, f_awwait, f_wlast, f_b;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      fifo_vld = 1'b0; fifo_din = '0;
      forever begin
         @(negedge clk);
         f_pop    = fifo_vld && fifo_rdy;
         f_aw     = awvalid && awready;
         f_awwait = awvalid && !awready;
         f_wlast  = wvalid && wready && wlast;
         f_b      = bvalid && bready;
         @(posedge clk);
         #1;
         if (!rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; fifo_vld = 1'b0;
            aw_low = 0;
         end else begin
            if (f_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (f_wlast) pending_b++;
            if (f_b) begin
               pending_b--;
               b_idx++;
            end
            if (f_aw) aw_low = 0;
            else if (f_awwait) aw_low++;
            awready  = (aw_low >= aw_delay) && (bp_mode == 0 || $urandom_range(0, 3) != 0);
            wready   = (bp_mode == 0) ? 1'b1 :
                       (bp_mode == 1) ? ~wready : ($urandom_range(0, 2) != 0);
            fifo_vld = (fifo_q.size() > 0) && (bp_mode == 0 || $urandom_range(0, 4) != 0);
            fifo_din = (fifo_q.size() > 0) ? fifo_q[0]
                                           : {$urandom, $urandom, $urandom, $urandom};
            bvalid   = (pending_b > 0) && (bp_mode == 0 || $urandom_range(0, 2) == 0);
            bresp    = (b_idx == err_burst) ? 2'b10 : 2'b00;
         end
      end
   end

   // monitor: compares everything the DUT presents against the scoreboard
   initial begin : monitor
      logic [128:0] ew;
      logic [31:0]  ea;
      logic [7:0]   el;
      bit           ee;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (prev_done) chk(!done, "done_single_cycle", done, 0);
            prev_done = done;
            if (busy_chk && cyc == start_cyc + 1) begin
               chk(busy, "busy_after_start", busy, 1);
               busy_chk = 0;
            end
            if (awvalid) begin
               chk(!wvalid, "aw_w_overlap", wvalid, 0);
               if (aw_hold) begin
                  chk(awaddr == hold_addr, "aw_addr_stable", awaddr, hold_addr);
                  chk(awlen == hold_len, "aw_len_stable", awlen, hold_len);
               end
               if (first_aw_wait) begin
                  chk(cyc == start_cyc + 2, "aw_latency", cyc - start_cyc, 2);
                  first_aw_wait = 0;
               end
               if (awready) begin
                  chk(exp_aw_addr.size() > 0, "aw_expected", exp_aw_addr.size(), 1);
                  if (exp_aw_addr.size() > 0) begin
                     ea = exp_aw_addr.pop_front();
                     el = exp_aw_len.pop_front();
                     chk(awaddr == ea, "awaddr", awaddr, ea);
                     chk(awlen == el, "awlen", awlen, el);
                     chk(awsize == 3'd4, "awsize", awsize, 4);
                     chk(awburst == 2'b01, "awburst", awburst, 1);
                  end
                  aw_hold = 0;
               end else begin
                  aw_hold   = 1;
                  hold_addr = awaddr;
                  hold_len  = awlen;
               end
            end
            if (wvalid && wready) begin
               chk(exp_w.size() > 0, "w_expected", exp_w.size(), 1);
               if (exp_w.size() > 0) begin
                  ew = exp_w.pop_front();
                  chk(wdata == ew[127:0], "wdata", wdata, ew[127:0]);
                  chk(wlast == ew[128], "wlast", wlast, ew[128]);
                  chk(wstrb == 16'hFFFF, "wstrb", wstrb, 16'hFFFF);
                  chk(fifo_rdy, "fifo_rdy_on_beat", fifo_rdy, 1);
               end
               w_pops++;
            end
            if (bvalid && bready) bfire_cyc = cyc;
            if (done) begin
               chk(!busy, "busy_at_done", busy, 0);
               chk(exp_done.size() > 0, "done_expected", exp_done.size(), 1);
               if (exp_done.size() > 0) begin
                  ee = exp_done.pop_front();
                  chk(error == ee, "error_at_done", error, ee);
               end
               chk(exp_aw_addr.size() == 0 && exp_w.size() == 0, "traffic_left_at_done",
                   exp_aw_addr.size() + exp_w.size(), 0);
               if (zero_job) chk(cyc == start_cyc + 1, "zero_job_done_latency", cyc - start_cyc, 1);
               else          chk(cyc == bfire_cyc + 1, "done_after_b", cyc - bfire_cyc, 1);
               done_cnt++;
            end
            if (start && !busy && !done) begin
               start_cyc     = cyc;
               zero_job      = (num_beats == 0);
               first_aw_wait = (num_beats != 0);
               busy_chk      = (num_beats != 0);
            end
         end
      end
   end

   // reference model: split the job into bursts from the addressing rules
   task automatic plan_job(input logic [31:0] base, input int n, input int err,
                           input int stage, output int written,
                           output logic [127:0] words[$]);
      logic [31:0] a;
      int rem, len, bnd, idx;
      bit err_hit;
      a = base & 32'hFFFF_FFF0;
      rem = n; idx = 0; written = 0; err_hit = 0;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom, $urandom, $urandom});
      while (rem > 0) begin
         bnd = (4096 - int'(a % 4096)) / 16;
         len = rem;
         if (len > MAXB) len = MAXB;
         if (len > bnd) len = bnd;
         exp_aw_addr.push_back(a);
         exp_aw_len.push_back(8'(len - 1));
         for (int k = 0; k < len; k++) exp_w.push_back({k == len - 1, words[written + k]});
         written += len;
         a = a + 32'(len * 16);
         rem -= len;
         if (idx == err) begin
            err_hit = 1;
`ifdef SIMON_AXI_WR_ERR_ABORT_EN
            break;
`endif
         end
         idx++;
      end
      exp_done.push_back(err_hit);
      for (int i = 0; i < n && (stage == 0 || i < stage); i++) fifo_q.push_back(words[i]);
   endtask

   task automatic pulse_start(input logic [31:0] base, input int n);
      @(posedge clk); #2;
      base_addr = base; num_beats = 20'(n); start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0; base_addr = $urandom; num_beats = 20'($urandom);
   endtask

   task automatic wait_done(input int target);
      int t = 0;
      while (done_cnt < target && t < 5000) begin
         @(posedge clk);
         t++;
      end
      chk(done_cnt >= target, "done_timeout", done_cnt, target);
   endtask

   task automatic run_job(input logic [31:0] base, input int n, input int err,
                          input int awd, input int bp, input int stage, input bit spurious);
      logic [127:0] words[$];
      int written, target;
      plan_job(base, n, err, stage, written, words);
      err_burst = err; b_idx = 0; aw_delay = awd; bp_mode = bp; w_pops = 0;
      target = done_cnt + 1;
      pulse_start(base, n);
      if (spurious) begin
         repeat (3) @(posedge clk);
         #2;
         base_addr = 32'h7000; num_beats = 20'd5; start = 1'b1;
         @(posedge clk); #2;
         start = 1'b0;
      end
      if (stage > 0) begin
         repeat (8) @(posedge clk);
         #2;
         for (int i = stage; i < n; i++) fifo_q.push_back(words[i]);
      end
      wait_done(target);
      repeat (2) @(posedge clk);
      #2;
      chk(w_pops == written, "beat_count", w_pops, written);
      chk(fifo_q.size() == n - written, "fifo_leftover", fifo_q.size(), n - written);
      fifo_q.delete();
      err_burst = -1;
   endtask

   initial begin : stimulus
      logic [127:0] words[$];
      logic [31:0] b;
      int n, e, written, t;
      rst = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(busy == 0, "rst_busy", busy, 0);
      chk(done == 0, "rst_done", done, 0);
      chk(error == 0, "rst_error", error, 0);
      chk(awvalid == 0, "rst_awvalid", awvalid, 0);
      chk(wvalid == 0, "rst_wvalid", wvalid, 0);
      chk(wlast == 0, "rst_wlast", wlast, 0);
      chk(bready == 0, "rst_bready", bready, 0);
      chk(fifo_rdy == 0, "rst_fifo_rdy", fifo_rdy, 0);
      chk(awaddr == 0, "rst_awaddr", awaddr, 0);
      chk(awlen == 0, "rst_awlen", awlen, 0);
      @(posedge clk); #2;
      rst = 1'b1;

      run_job(32'h0000_1000, 4, -1, 0, 0, 0, 0);   // single burst
      run_job(32'h0000_0000, 20, -1, 0, 0, 0, 0);  // split at the burst cap
      run_job(32'h0000_0FE0, 4, -1, 0, 0, 0, 0);   // 4 KB boundary split
      run_job(32'h0000_2000, 12, -1, 5, 1, 2, 1);  // backpressure + ignored start
      run_job(32'h0000_0000, 20, 0, 0, 0, 0, 0);   // error on first burst
      run_job(32'h0000_3000, 0, -1, 0, 0, 0, 0);   // zero-length job
      run_job(32'hFFFF_FFF7, 3, -1, 0, 0, 0, 0);   // low bits ignored, address wrap

      // reset in the middle of a W burst, then a normal job
      plan_job(32'h0000_4000, 20, -1, 0, written, words);
      err_burst = -1; b_idx = 0; aw_delay = 0; bp_mode = 0; w_pops = 0;
      pulse_start(32'h0000_4000, 20);
      t = 0;
      while (w_pops < 3 && t < 500) begin
         @(posedge clk);
         t++;
      end
      chk(w_pops >= 3, "reset_reach_w", w_pops, 3);
      #2;
      rst = 1'b0;
      #1;
      chk(busy == 0, "midrst_busy", busy, 0);
      chk(done == 0, "midrst_done", done, 0);
      chk(awvalid == 0, "midrst_awvalid", awvalid, 0);
      chk(wvalid == 0, "midrst_wvalid", wvalid, 0);
      chk(wlast == 0, "midrst_wlast", wlast, 0);
      chk(bready == 0, "midrst_bready", bready, 0);
      chk(fifo_rdy == 0, "midrst_fifo_rdy", fifo_rdy, 0);
      chk(awaddr == 0, "midrst_awaddr", awaddr, 0);
      chk(awlen == 0, "midrst_awlen", awlen, 0);
      exp_aw_addr.delete(); exp_aw_len.delete(); exp_w.delete(); exp_done.delete();
      fifo_q.delete();
      pending_b = 0; aw_hold = 0; first_aw_wait = 0; prev_done = 0; busy_chk = 0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      run_job(32'h0000_4000, 5, -1, 0, 0, 0, 0);

      // randomized jobs, half of them starting near a 4 KB page end
      for (int j = 0; j < 10; j++) begin
         b = $urandom;
         if (j % 2 == 0) b[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
         n = $urandom_range(1, 40);
         e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
         run_job(b, n, e, $urandom_range(0, 3), 2, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
